// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction memory
// and hands registered instructions to decode over a valid/ready handshake.
module fetch_unit #(
   parameter int MEM_DEPTH = 10,
   parameter int RESET_PC  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        running,
   output logic        addr_err,
   output logic [31:0] fetch_count
);

   localparam int DATA_W = 32;
   localparam int PC_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc;
   logic            slot_free;
   logic            fetch_en;
   logic            redir_ok;

   function automatic logic [PC_W-1:0] pc_wrap_inc(input logic [PC_W-1:0] p);
      if (p == PC_W'(MEM_DEPTH - 1))
         return '0;
      else
         return p + PC_W'(1);
   endfunction

   assign slot_free = !instr_valid || instr_ready;
   assign redir_ok  = (redirect_addr < DATA_W'(MEM_DEPTH));
   assign mem_addr  = {{(DATA_W-PC_W){1'b0}}, pc};
   assign running   = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // halt dominates start; a halting or redirecting edge never fetches
   always_comb begin
      state_nxt = state;
      fetch_en  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !halt)
               state_nxt = RUN;
         end
         RUN: begin
            if (halt)
               state_nxt = IDLE;
            else
               fetch_en = !redirect_valid && slot_free;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // output slot register: redirect flush beats fetch, fetch beats plain accept
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= PC_W'(RESET_PC);
         instr_out   <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         addr_err    <= 1'b0;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         instr_valid <= 1'b0;
         if (redir_ok) begin
            pc <= redirect_addr[PC_W-1:0];
         end else begin
            pc       <= '0;
            addr_err <= 1'b1;
         end
      end else if (fetch_en) begin
         instr_out   <= mem_data;
         instr_pc    <= {{(DATA_W-PC_W){1'b0}}, pc};
         instr_valid <= 1'b1;
         fetch_count <= fetch_count + 32'd1;
         pc          <= pc_wrap_inc(pc);
      end else if (instr_ready) begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural 10-word memory, a scoreboard of expected
// (pc, instruction) pairs consumed on every accepted handshake, plus directed checks.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        halt = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_addr = '0;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        running;
   logic        addr_err;
   logic [31:0] fetch_count;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   fetch_unit #(.MEM_DEPTH(10), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .running(running), .addr_err(addr_err),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      logic [3:0] n;
      if (a >= 32'd10) return 32'hDEAD_BEEF;
      n = (a == 32'd0) ? 4'hA : a[3:0];
      return {n, 20'h0, n, n};
   endfunction

   assign mem_data = word_of(mem_addr);

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic push_pc(input int p);
      sb_q.push_back({32'(p), word_of(32'(p))});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      instr_ready = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // a handshake seen at the falling edge completes on the next rising edge
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_depth", 32'(sb_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_instr", instr_out, e.instr);
            chk("sb_pc", instr_pc, e.pc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      do_reset();
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_addr_err", 32'(addr_err), 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_instr", instr_out, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);

      // streaming with wrap: pcs 0..9,0,1
      for (int i = 0; i < 12; i++) push_pc(i % 10);
      instr_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_running", 32'(running), 32'd1);
      chk("start_valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 12; i++) step();
      chk("stream_count", fetch_count, 32'd12);
      chk("stream_last_pc", instr_pc, 32'd1);
      chk("stream_last_instr", instr_out, 32'h1000_0011);
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("halt1_running", 32'(running), 32'd0);
      chk("halt1_valid", 32'(instr_valid), 32'd0);
      chk("halt1_mem_addr", mem_addr, 32'd2);
      chk("stream_drain", 32'(sb_q.size()), 32'd0);

      // backpressure on pc 3
      do_reset();
      for (int i = 0; i < 5; i++) push_pc(i);
      instr_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("bp_instr", instr_out, 32'h3000_0033);
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_instr", instr_out, 32'h3000_0033);
         chk("bp_hold_pc", instr_pc, 32'd3);
         chk("bp_hold_valid", 32'(instr_valid), 32'd1);
         chk("bp_hold_mem_addr", mem_addr, 32'd4);
         chk("bp_hold_count", fetch_count, 32'd4);
      end
      instr_ready = 1'b1;
      step();
      chk("bp_resume_instr", instr_out, 32'h4000_0044);
      chk("bp_resume_pc", instr_pc, 32'd4);
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("bp_halt_valid", 32'(instr_valid), 32'd0);
      chk("bp_drain", 32'(sb_q.size()), 32'd0);

      // redirect to 7 while a valid instruction is stalled
      do_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("redir_pre_valid", 32'(instr_valid), 32'd1);
      chk("redir_pre_pc", instr_pc, 32'd0);
      redirect_valid = 1'b1;
      redirect_addr = 32'd7;
      step();
      redirect_valid = 1'b0;
      chk("redir_flush_valid", 32'(instr_valid), 32'd0);
      chk("redir_mem_addr", mem_addr, 32'd7);
      chk("redir_count", fetch_count, 32'd1);
      push_pc(7);
      instr_ready = 1'b1;
      step();
      chk("redir_instr", instr_out, 32'h7000_0077);
      chk("redir_instr_pc", instr_pc, 32'd7);
      chk("redir_count2", fetch_count, 32'd2);
      halt = 1'b1;
      step();
      halt = 1'b0;

      // out-of-range redirect
      redirect_valid = 1'b1;
      redirect_addr = 32'd12;
      step();
      redirect_valid = 1'b0;
      chk("oor_addr_err", 32'(addr_err), 32'd1);
      chk("oor_mem_addr", mem_addr, 32'd0);
      chk("oor_running", 32'(running), 32'd0);
      push_pc(0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      instr_ready = 1'b0;
      chk("oor_instr", instr_out, 32'hA000_00AA);
      chk("oor_count", fetch_count, 32'd3);

      // halt and start together while running, with a pending instruction
      halt = 1'b1;
      start = 1'b1;
      step();
      halt = 1'b0;
      start = 1'b0;
      chk("hs_running", 32'(running), 32'd0);
      chk("hs_valid", 32'(instr_valid), 32'd1);
      chk("hs_instr", instr_out, 32'hA000_00AA);
      chk("hs_mem_addr", mem_addr, 32'd1);
      step();
      step();
      chk("hs_hold_valid", 32'(instr_valid), 32'd1);
      chk("hs_hold_count", fetch_count, 32'd3);
      instr_ready = 1'b1;
      step();
      chk("hs_accept_valid", 32'(instr_valid), 32'd0);
      chk("hs_accept_mem_addr", mem_addr, 32'd1);
      push_pc(1);
      push_pc(2);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("resume_pc1", instr_pc, 32'd1);
      step();
      chk("resume_pc2", instr_pc, 32'd2);
      chk("resume_count", fetch_count, 32'd5);
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("sticky_addr_err", 32'(addr_err), 32'd1);

      // reset mid-run with a valid instruction in the slot
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      instr_ready = 1'b0;
      chk("mid_pre_valid", 32'(instr_valid), 32'd1);
      chk("mid_pre_pc", instr_pc, 32'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_running", 32'(running), 32'd0);
      chk("mid_rst_addr_err", 32'(addr_err), 32'd0);
      chk("mid_rst_count", fetch_count, 32'd0);
      chk("mid_rst_instr", instr_out, 32'd0);
      chk("mid_rst_instr_pc", instr_pc, 32'd0);
      chk("mid_rst_mem_addr", mem_addr, 32'd0);
      push_pc(0);
      push_pc(1);
      instr_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("restart_instr", instr_out, 32'hA000_00AA);
      step();
      chk("restart_count", fetch_count, 32'd2);
      halt = 1'b1;
      step();
      halt = 1'b0;
      step();
      chk("final_drain", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
